// File: rtl/sram_master.sv
// Single-request load/store initiator for a 64-bit byte-laned SRAM port.
// Splits accesses that straddle an 8-byte boundary and extends load data.
module sram_master #(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic [7:0]  mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, A0, A1, CAP, RESP} state_t;

  state_t      state_q, state_d;
  logic        r_we, r_signed, r_err;
  logic [1:0]  r_size;
  logic [63:0] r_addr, r_wdata, lo_q, rdata_q;

  logic        accept, in_err;
  logic [3:0]  in_n, r_n;
  logic [64:0] req_end, win_end;
  logic [2:0]  off;
  logic        split;
  logic [63:0] base;
  logic [5:0]  sh_lo, sh_hi;
  logic [7:0]  lane_mask;
  logic [63:0] lo_src, raw, ext;

  assign accept  = req_valid && (state_q == IDLE);
  assign in_n    = 4'd1 << req_size;
  // 65-bit sums so an address near the top of the space cannot wrap past the check
  assign req_end = {1'b0, req_addr} + {61'b0, in_n};
  assign win_end = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  assign in_err  = (req_addr < MEM_BASE) || (req_end > win_end);

  assign r_n       = 4'd1 << r_size;
  assign off       = r_addr[2:0];
  assign split     = ({1'b0, off} + r_n) > 4'd8;
  assign base      = {r_addr[63:3], 3'b000};
  assign sh_lo     = {off, 3'b000};
  // 64 - 8*off modulo 64; only used when split, where off is never 0
  assign sh_hi     = 6'd0 - sh_lo;
  assign lane_mask = 8'((9'd1 << r_n) - 9'd1);

  always_comb begin
    lo_src = split ? lo_q : mem_rdata;
    raw    = (lo_src >> sh_lo) | (split ? (mem_rdata << sh_hi) : '0);
    ext    = '0;
    case (r_size)
      2'd0: ext = {{56{r_signed & raw[7]}},  raw[7:0]};
      2'd1: ext = {{48{r_signed & raw[15]}}, raw[15:0]};
      2'd2: ext = {{32{r_signed & raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        r_we     <= req_we;
        r_signed <= req_signed;
        r_err    <= in_err;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        rdata_q  <= '0;
      end
      if (state_q == A1 && !r_we) lo_q <= mem_rdata;
      if (state_q == CAP && !r_we) rdata_q <= ext;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = in_err ? RESP : A0;
      end
      A0: begin
        mem_en   = 1'b1;
        mem_addr = base;
        if (r_we) begin
          mem_we    = lane_mask << off;
          mem_wdata = r_wdata << sh_lo;
        end
        state_d = split ? A1 : CAP;
      end
      A1: begin
        mem_en   = 1'b1;
        mem_addr = base + 64'd8;
        if (r_we) begin
          mem_we    = lane_mask >> (4'd8 - {1'b0, off});
          mem_wdata = r_wdata >> sh_hi;
        end
        state_d = CAP;
      end
      CAP: state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = resp_valid & r_err;

endmodule
